// File: rtl/char_buf_arbiter.sv
// char_buf_arbiter: character text buffer for the character-rectangle
// renderer. One registered read port serves the renderer. Two game-logic
// requesters (A: score/status, B: messages) share one write port through a
// round-robin arbiter. A full-buffer blanking sweep runs after reset and
// whenever clr is pulsed.
module char_buf_arbiter #(
  parameter int         TEXT_COLS  = 16,
  parameter int         TEXT_ROWS  = 16,
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter bit         VBLNK_ONLY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk_in,
  input  logic       clr,
  input  logic       req_a,
  input  logic [7:0] addr_a,
  input  logic [7:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [7:0] addr_b,
  input  logic [7:0] data_b,
  output logic       ack_b,
  input  logic [7:0] char_xy_w,
  output logic [7:0] addr_x_w,
  output logic       busy,
  output logic       wr_err
);

  localparam int DEPTH = TEXT_COLS * TEXT_ROWS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [8:0]    DEPTH_W  = 9'(DEPTH);

  // The buffer is addressed with 8-bit indices, so it can never exceed 256.
  generate
    if (DEPTH > 256 || DEPTH < 1) begin : g_depth_check
      $error("char_buf_arbiter: TEXT_COLS*TEXT_ROWS must be in 1..256");
    end
  endgenerate

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          rr_reg, rr_next;      // 0 = A has priority, 1 = B has priority
  logic [1:0]    ack_vec_reg;
  logic          wr_err_reg;

  // Requester-side views, index 0 = A, index 1 = B.
  logic [1:0]    req_vec;
  logic [7:0]    addr_vec [2];
  logic [7:0]    data_vec [2];
  logic [1:0]    elig;
  logic [1:0]    in_range;
  logic [1:0]    grant;
  logic          slot;

  // RAM write port controls.
  logic          we;
  logic [AW-1:0] wr_idx;
  logic [7:0]    wr_data;

  // Read side.
  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data_reg;
  logic          rd_valid_reg;
  logic          rd_oob_reg;
  logic          rd_in_range;

  assign req_vec     = {req_b, req_a};
  assign addr_vec[0] = addr_a;
  assign addr_vec[1] = addr_b;
  assign data_vec[0] = data_a;
  assign data_vec[1] = data_b;

  // A requester whose ack is showing this cycle is still holding its old
  // request; skipping it prevents the same write from landing twice.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign elig[gi]     = req_vec[gi] & ~ack_vec_reg[gi];
      assign in_range[gi] = ({1'b0, addr_vec[gi]} < DEPTH_W);
    end
  endgenerate

  // FSM state register: sweep state and sweep counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // FSM next state: sweep until the last index, clr restarts from zero.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_CLEAR: begin
        if (clr) begin
          cnt_next = '0;
        end else if (cnt_reg == LAST_IDX) begin
          state_next = ST_SERVE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + AW'(1);
        end
      end
      ST_SERVE: begin
        if (clr) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM outputs: busy flag and the write-slot qualifier.
  always_comb begin
    busy = (state_reg == ST_CLEAR);
    slot = (state_reg == ST_SERVE) && (!VBLNK_ONLY || vblnk_in) && !clr;
  end

  // Round-robin grant: a lone eligible requester wins outright; a tie goes
  // to the priority side and hands priority to the other side.
  always_comb begin
    grant   = 2'b00;
    rr_next = rr_reg;
    if (slot) begin
      if (&elig) begin
        grant   = rr_reg ? 2'b10 : 2'b01;
        rr_next = ~rr_reg;
      end else begin
        grant = elig;
      end
    end
  end

  // RAM write mux: the sweep owns the port in CLEAR, a granted requester in
  // SERVE. Out-of-range requests are acked but never reach the RAM.
  always_comb begin
    we      = 1'b0;
    wr_idx  = cnt_reg;
    wr_data = BLANK_CHAR;
    if (state_reg == ST_CLEAR) begin
      we = 1'b1;
    end else if (grant[1]) begin
      we      = in_range[1];
      wr_idx  = addr_vec[1][AW-1:0];
      wr_data = data_vec[1];
    end else if (grant[0]) begin
      we      = in_range[0];
      wr_idx  = addr_vec[0][AW-1:0];
      wr_data = data_vec[0];
    end
  end

  // Ack / error pulses and arbitration pointer commit with the write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_vec_reg <= 2'b00;
      wr_err_reg  <= 1'b0;
      rr_reg      <= 1'b0;
    end else begin
      ack_vec_reg <= grant;
      wr_err_reg  <= |(grant & ~in_range);
      rr_reg      <= rr_next;
    end
  end

  assign ack_a  = ack_vec_reg[0];
  assign ack_b  = ack_vec_reg[1];
  assign wr_err = wr_err_reg;

  // Buffer RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_in_range = ({1'b0, char_xy_w} < DEPTH_W);

  // Registered RAM read; same-cycle write to the same index returns old data.
  always_ff @(posedge clk) begin
    rd_data_reg <= mem[char_xy_w[AW-1:0]];
  end

  // Read qualifiers kept outside the RAM so the data register stays reset-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_reg <= 1'b0;
      rd_oob_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b1;
      rd_oob_reg   <= ~rd_in_range;
    end
  end

  // Renderer output: zero out of reset, blank for indices past the buffer.
  always_comb begin
    if (!rd_valid_reg) begin
      addr_x_w = 8'h00;
    end else if (rd_oob_reg) begin
      addr_x_w = BLANK_CHAR;
    end else begin
      addr_x_w = rd_data_reg;
    end
  end

endmodule

// File: tb/tb_char_buf_arbiter.sv
// Self-checking bench for char_buf_arbiter (16x8 buffer, vblank-only writes).
module tb_char_buf_arbiter;

  localparam int         TC    = 16;
  localparam int         TR    = 8;
  localparam int         DEPTH = TC * TR;
  localparam logic [7:0] BLANK = 8'h20;

  logic       clk = 1'b0;
  logic       rst;
  logic       vblnk_in;
  logic       clr;
  logic       req_a;
  logic [7:0] addr_a;
  logic [7:0] data_a;
  logic       ack_a;
  logic       req_b;
  logic [7:0] addr_b;
  logic [7:0] data_b;
  logic       ack_b;
  logic [7:0] char_xy_w;
  logic [7:0] addr_x_w;
  logic       busy;
  logic       wr_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_mem [256];

  char_buf_arbiter #(
    .TEXT_COLS (TC),
    .TEXT_ROWS (TR),
    .BLANK_CHAR(BLANK),
    .VBLNK_ONLY(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vblnk_in (vblnk_in),
    .clr      (clr),
    .req_a    (req_a),
    .addr_a   (addr_a),
    .data_a   (data_a),
    .ack_a    (ack_a),
    .req_b    (req_b),
    .addr_b   (addr_b),
    .data_b   (data_b),
    .ack_b    (ack_b),
    .char_xy_w(char_xy_w),
    .addr_x_w (addr_x_w),
    .busy     (busy),
    .wr_err   (wr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic blank_model();
    for (int i = 0; i < 256; i++) model_mem[i] = BLANK;
  endtask

  task automatic test_reset();
    int n;
    int rd_list [5] = '{0, 77, 127, 128, 200};
    rst = 1'b0; vblnk_in = 1'b0; clr = 1'b0;
    req_a = 1'b0; addr_a = '0; data_a = '0;
    req_b = 1'b0; addr_b = '0; data_b = '0;
    char_xy_w = '0;
    tick(); tick();
    checks++; if (addr_x_w !== 8'h00) begin failures++; $display("FAIL reset_addr_x_w got=%h exp=00", addr_x_w); end
    checks++; if (ack_a !== 1'b0 || ack_b !== 1'b0) begin failures++; $display("FAIL reset_acks got=%b%b exp=00", ack_a, ack_b); end
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL reset_wr_err got=%b exp=0", wr_err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    rst = 1'b1;
    n = 0;
    do begin tick(); n++; end while (busy === 1'b1 && n < 1000);
    checks++; if (n != DEPTH) begin failures++; $display("FAIL reset_sweep_len got=%0d exp=%0d", n, DEPTH); end
    blank_model();
    foreach (rd_list[i]) begin
      char_xy_w = 8'(rd_list[i]);
      tick();
      checks++; if (addr_x_w !== BLANK) begin failures++; $display("FAIL reset_read idx=%0d got=%h exp=%h", rd_list[i], addr_x_w, BLANK); end
    end
  endtask

  task automatic test_single_write();
    vblnk_in = 1'b1;
    req_a = 1'b1; addr_a = 8'd5; data_a = 8'h41;
    tick();
    checks++; if (ack_a !== 1'b1 || ack_b !== 1'b0 || wr_err !== 1'b0) begin failures++; $display("FAIL single_ack got=a%b b%b e%b exp=a1 b0 e0", ack_a, ack_b, wr_err); end
    tick();
    checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL single_no_double_ack got=%b exp=0", ack_a); end
    req_a = 1'b0;
    model_mem[5] = 8'h41;
    char_xy_w = 8'd5;
    tick();
    checks++; if (addr_x_w !== 8'h41) begin failures++; $display("FAIL single_readback got=%h exp=41", addr_x_w); end
  endtask

  task automatic test_round_robin();
    logic [7:0] last_a;
    logic [7:0] last_b;
    vblnk_in = 1'b1;
    req_a = 1'b1; addr_a = 8'($urandom_range(0, DEPTH/2 - 1)); data_a = 8'($urandom);
    req_b = 1'b1; addr_b = 8'($urandom_range(DEPTH/2, DEPTH - 1)); data_b = 8'($urandom);
    last_a = addr_a; last_b = addr_b;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (ack_a !== (i % 2 == 0) || ack_b !== (i % 2 == 1)) begin
        failures++; $display("FAIL rr_order cycle=%0d got=a%b b%b exp=a%0d b%0d", i, ack_a, ack_b, (i % 2 == 0), (i % 2 == 1));
      end
      if (i % 2 == 0) begin
        model_mem[addr_a] = data_a; last_a = addr_a;
        addr_a = 8'($urandom_range(0, DEPTH/2 - 1)); data_a = 8'($urandom);
      end else begin
        model_mem[addr_b] = data_b; last_b = addr_b;
        addr_b = 8'($urandom_range(DEPTH/2, DEPTH - 1)); data_b = 8'($urandom);
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    char_xy_w = last_a;
    tick();
    checks++; if (addr_x_w !== model_mem[last_a]) begin failures++; $display("FAIL rr_readback_a got=%h exp=%h", addr_x_w, model_mem[last_a]); end
    char_xy_w = last_b;
    tick();
    checks++; if (addr_x_w !== model_mem[last_b]) begin failures++; $display("FAIL rr_readback_b got=%h exp=%h", addr_x_w, model_mem[last_b]); end
  endtask

  task automatic test_vblank_gate();
    int cnt;
    vblnk_in = 1'b0;
    req_b = 1'b1; addr_b = 8'd33; data_b = 8'($urandom);
    cnt = 0;
    repeat (100) begin tick(); if (ack_b === 1'b1) cnt++; end
    checks++; if (cnt != 0) begin failures++; $display("FAIL vblank_hold got=%0d acks exp=0", cnt); end
    vblnk_in = 1'b1;
    tick();
    checks++; if (ack_b !== 1'b1) begin failures++; $display("FAIL vblank_rise_ack got=%b exp=1", ack_b); end
    model_mem[33] = data_b;
    req_b = 1'b0;
    // Grant in the final blank cycle must still complete.
    req_a = 1'b1; addr_a = 8'd40; data_a = 8'h6b;
    tick();
    vblnk_in = 1'b0;
    req_a = 1'b0;
    checks++; if (ack_a !== 1'b1) begin failures++; $display("FAIL vblank_last_cycle_ack got=%b exp=1", ack_a); end
    model_mem[40] = 8'h6b;
    char_xy_w = 8'd40;
    tick();
    checks++; if (addr_x_w !== 8'h6b) begin failures++; $display("FAIL vblank_last_cycle_data got=%h exp=6b", addr_x_w); end
    char_xy_w = 8'd33;
    tick();
    checks++; if (addr_x_w !== model_mem[33]) begin failures++; $display("FAIL vblank_b_data got=%h exp=%h", addr_x_w, model_mem[33]); end
  endtask

  task automatic test_out_of_range();
    vblnk_in = 1'b1;
    req_a = 1'b1; addr_a = 8'd255; data_a = 8'h99;
    tick();
    req_a = 1'b0;
    checks++; if (ack_a !== 1'b1 || wr_err !== 1'b1) begin failures++; $display("FAIL oob_255 got=a%b e%b exp=a1 e1", ack_a, wr_err); end
    tick();
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL oob_err_pulse got=%b exp=0", wr_err); end
    char_xy_w = 8'd127;
    tick();
    checks++; if (addr_x_w !== model_mem[127]) begin failures++; $display("FAIL oob_127_untouched got=%h exp=%h", addr_x_w, model_mem[127]); end
    req_b = 1'b1; addr_b = 8'(DEPTH); data_b = 8'h11;
    tick();
    req_b = 1'b0;
    checks++; if (ack_b !== 1'b1 || wr_err !== 1'b1) begin failures++; $display("FAIL oob_depth_b got=b%b e%b exp=b1 e1", ack_b, wr_err); end
    req_a = 1'b1; addr_a = 8'(DEPTH - 1); data_a = 8'h55;
    tick();
    req_a = 1'b0;
    checks++; if (ack_a !== 1'b1 || wr_err !== 1'b0) begin failures++; $display("FAIL oob_last_in_range got=a%b e%b exp=a1 e0", ack_a, wr_err); end
    model_mem[DEPTH - 1] = 8'h55;
    char_xy_w = 8'(DEPTH - 1);
    tick();
    checks++; if (addr_x_w !== 8'h55) begin failures++; $display("FAIL oob_last_readback got=%h exp=55", addr_x_w); end
    char_xy_w = 8'd200;
    tick();
    checks++; if (addr_x_w !== BLANK) begin failures++; $display("FAIL oob_read_200 got=%h exp=%h", addr_x_w, BLANK); end
  endtask

  task automatic test_clr_pending();
    int n;
    int bad;
    vblnk_in = 1'b1;
    clr = 1'b1;
    req_a = 1'b1; addr_a = 8'd7; data_a = 8'h77;
    tick();
    clr = 1'b0;
    checks++; if (ack_a !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL clr_cycle got=a%b busy%b exp=a0 busy1", ack_a, busy); end
    n = 1; bad = 0;
    while (n < 1000) begin
      tick();
      if (busy === 1'b1) begin
        n++;
        if (ack_a !== 1'b0) bad++;
      end else begin
        break;
      end
    end
    checks++; if (n != DEPTH) begin failures++; $display("FAIL clr_sweep_len got=%0d exp=%0d", n, DEPTH); end
    checks++; if (bad != 0) begin failures++; $display("FAIL clr_ack_while_busy got=%0d exp=0", bad); end
    tick();
    checks++; if (ack_a !== 1'b1) begin failures++; $display("FAIL clr_pending_ack got=%b exp=1", ack_a); end
    req_a = 1'b0;
    blank_model();
    model_mem[7] = 8'h77;
    char_xy_w = 8'd7;
    tick();
    checks++; if (addr_x_w !== 8'h77) begin failures++; $display("FAIL clr_pending_data got=%h exp=77", addr_x_w); end
    char_xy_w = 8'd5;
    tick();
    checks++; if (addr_x_w !== BLANK) begin failures++; $display("FAIL clr_blanked got=%h exp=%h", addr_x_w, BLANK); end
  endtask

  task automatic test_clr_extend();
    int n;
    int k = 50;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 1;
    for (int i = 1; i < k; i++) begin tick(); n++; end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n++;
    while (n < 2000) begin
      tick();
      if (busy === 1'b1) n++; else break;
    end
    checks++; if (n != k + DEPTH) begin failures++; $display("FAIL clr_extend_len got=%0d exp=%0d", n, k + DEPTH); end
    blank_model();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (30) tick();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || addr_x_w !== 8'h00 || ack_a !== 1'b0 || ack_b !== 1'b0) begin
      failures++; $display("FAIL midsweep_reset got=busy%b x%h a%b b%b exp=busy1 x00 a0 b0", busy, addr_x_w, ack_a, ack_b);
    end
    tick();
    rst = 1'b1;
    n = 0;
    do begin tick(); n++; end while (busy === 1'b1 && n < 1000);
    checks++; if (n != DEPTH) begin failures++; $display("FAIL midsweep_sweep_len got=%0d exp=%0d", n, DEPTH); end
    blank_model();
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 8'($urandom_range(DEPTH, 255));
    return 8'($urandom_range(0, DEPTH - 1));
  endfunction

  // Random traffic against a transaction-level model of the buffer.
  task automatic test_random();
    int         sweep_left;
    logic       exp_ack_a, exp_ack_b, exp_err;
    logic       prio_b;
    logic       ea, eb, ga, gb, slot, rd_ok;
    logic [7:0] exp_rd;
    int         idx;
    rst = 1'b0; clr = 1'b0; req_a = 1'b0; req_b = 1'b0; vblnk_in = 1'b0;
    tick();
    rst = 1'b1;
    sweep_left = DEPTH; exp_ack_a = 1'b0; exp_ack_b = 1'b0; prio_b = 1'b0;
    blank_model();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      slot = (sweep_left == 0) && vblnk_in && !clr;
      ea = req_a && !exp_ack_a;
      eb = req_b && !exp_ack_b;
      ga = 1'b0; gb = 1'b0;
      if (slot) begin
        if (ea && eb) begin
          if (prio_b) gb = 1'b1; else ga = 1'b1;
          prio_b = !prio_b;
        end else begin
          ga = ea; gb = eb;
        end
      end
      rd_ok  = (sweep_left == 0);
      idx    = int'(char_xy_w);
      exp_rd = (idx < DEPTH) ? model_mem[idx] : BLANK;
      exp_err = 1'b0;
      if (ga) begin if (int'(addr_a) < DEPTH) model_mem[addr_a] = data_a; else exp_err = 1'b1; end
      if (gb) begin if (int'(addr_b) < DEPTH) model_mem[addr_b] = data_b; else exp_err = 1'b1; end
      if (clr) begin sweep_left = DEPTH; blank_model(); end
      else if (sweep_left > 0) sweep_left--;
      tick();
      checks++; if (ack_a !== ga) begin failures++; $display("FAIL rand_ack_a cyc=%0d got=%b exp=%b", cyc, ack_a, ga); end
      checks++; if (ack_b !== gb) begin failures++; $display("FAIL rand_ack_b cyc=%0d got=%b exp=%b", cyc, ack_b, gb); end
      checks++; if (wr_err !== exp_err) begin failures++; $display("FAIL rand_wr_err cyc=%0d got=%b exp=%b", cyc, wr_err, exp_err); end
      checks++; if (busy !== (sweep_left > 0)) begin failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%0d", cyc, busy, (sweep_left > 0)); end
      if (rd_ok) begin
        checks++; if (addr_x_w !== exp_rd) begin failures++; $display("FAIL rand_read cyc=%0d idx=%0d got=%h exp=%h", cyc, idx, addr_x_w, exp_rd); end
      end
      exp_ack_a = ga; exp_ack_b = gb;
      clr = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 9) == 0) vblnk_in = !vblnk_in;
      char_xy_w = 8'($urandom_range(0, 159));
      if (!req_a) begin
        if ($urandom_range(0, 2) == 0) begin req_a = 1'b1; addr_a = rand_addr(); data_a = 8'($urandom); end
      end else if (ga) begin
        if ($urandom_range(0, 1) == 0) req_a = 1'b0;
        else begin addr_a = rand_addr(); data_a = 8'($urandom); end
      end
      if (!req_b) begin
        if ($urandom_range(0, 2) == 0) begin req_b = 1'b1; addr_b = rand_addr(); data_b = 8'($urandom); end
      end else if (gb) begin
        if ($urandom_range(0, 1) == 0) req_b = 1'b0;
        else begin addr_b = rand_addr(); data_b = 8'($urandom); end
      end
    end
    req_a = 1'b0; req_b = 1'b0; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_vblank_gate();
    test_out_of_range();
    test_clr_pending();
    test_clr_extend();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
